data_mem_responder: RTL and testbench



---
 rtl/cpu_pkg.sv | 13 +
 rtl/data_mem_responder_dmem_array.sv | 25 ++
 rtl/data_mem_responder.sv | 121 ++++++++++++
 tb/tb_data_mem_responder.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants and FSM encoding for the CPU memory-side blocks.
package cpu_pkg;

  localparam int WORD_W     = 32;
  localparam int BYTE_OFF_W = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } mem_state_e;

endpackage

// File: rtl/data_mem_responder_dmem_array.sv
// Single-port synchronous RAM, read-before-write, kept apart from the FSM
// so the storage maps onto a RAM macro on its own.
module dmem_array
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = WORD_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Word-addressed data-memory responder with fixed response latency.
// Optional misalignment checking is enabled with DATA_MEM_ALIGN_CHECK_EN.
module data_mem_responder
  import cpu_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic              req_wrenable,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] IDLE   = S_IDLE;
  localparam logic [1:0] WAIT   = S_WAIT;
  localparam logic [1:0] RESP   = S_RESP;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  logic [1:0]            state;
  logic [3:0]            count;
  logic [DEPTH_LOG2-1:0] req_index;
  logic [DEPTH_LOG2-1:0] held_index;
  logic [DEPTH_LOG2-1:0] ram_addr;
  logic [WORD_W-1:0]     ram_rdata;
  logic                  accept;
  logic                  misaligned;
  logic                  zero_data;
  logic                  unused_addr_bits;

  // Handshakes: a request transfers on a rising edge with req_valid && req_ready,
  // a response on a rising edge with resp_valid && resp_ready; the two never
  // coincide because req_ready is only high in IDLE and resp_valid only in RESP.
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign accept     = req_valid && (state == IDLE) && !reset;
  assign dbg_state  = state;

  assign req_index        = req_addr[DEPTH_LOG2+1:BYTE_OFF_W];
  assign unused_addr_bits = ^{req_addr[WORD_W-1:DEPTH_LOG2+2], req_addr[BYTE_OFF_W-1:0]};

`ifdef DATA_MEM_ALIGN_CHECK_EN
  logic err_q;

  assign misaligned = |req_addr[BYTE_OFF_W-1:0];
  assign resp_err   = (state == RESP) && err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= misaligned;
    end
  end
`else
  assign misaligned = 1'b0;
  assign resp_err   = 1'b0;
`endif

  // The RAM keeps re-reading the accepted word while the response is pending;
  // nothing writes outside the accept edge, so its output stays stable.
  assign ram_addr = (state == IDLE) ? req_index : held_index;

  dmem_array #(
    .ADDR_W (DEPTH_LOG2),
    .DATA_W (WORD_W)
  ) u_array (
    .clk   (clk),
    .we    (accept && req_wrenable && !misaligned),
    .addr  (ram_addr),
    .wdata (req_wdata),
    .rdata (ram_rdata)
  );

  assign resp_rdata = ((state == RESP) && !zero_data) ? ram_rdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      zero_data  <= 1'b1;
      held_index <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            held_index <= req_index;
            zero_data  <= req_wrenable || misaligned;
            if (LATENCY == 1) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              count <= LAT_M1;
            end
          end
        end
        WAIT: begin
          count <= 4'(count - 4'd1);
          if (count == 4'd1) begin
            state <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (LATENCY 2 and 1) checked every
// cycle against a transaction-level model, plus directed literal expectations.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset        [2];
  logic        req_valid    [2];
  logic        req_ready    [2];
  logic [31:0] req_addr     [2];
  logic [31:0] req_wdata    [2];
  logic        req_wrenable [2];
  logic        resp_valid   [2];
  logic        resp_ready   [2];
  logic [31:0] resp_rdata   [2];
  logic        resp_err     [2];
  logic [1:0]  dbg_state    [2];

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_LOG2(8), .LATENCY(2)) dut0 (
    .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wrenable(req_wrenable[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]),
    .resp_err(resp_err[0]), .dbg_state(dbg_state[0])
  );

  data_mem_responder #(.DEPTH_LOG2(8), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wrenable(req_wrenable[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]),
    .resp_err(resp_err[1]), .dbg_state(dbg_state[1])
  );

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  // Transaction-level model: one outstanding request, response visible from the
  // LATENCY-th cycle after acceptance until a cycle with resp_ready high.
  for (genvar g = 0; g < 2; g++) begin : gm
    localparam int LAT = (g == 0) ? 2 : 1;
    logic [31:0] mm [256];
    bit          kn [256];
    bit          busy = 1'b0;
    int          age  = 0;
    logic [31:0] ed   = '0;
    bit          ee   = 1'b0;
    bit          ek   = 1'b0;
    int          idx;
    bit          mis;
    bit          exp_v;

    initial for (int k = 0; k < 256; k++) kn[k] = 1'b0;

    always @(posedge clk) begin
      if (reset[g]) begin
        busy = 1'b0;
      end else if (busy) begin
        if (age >= LAT && resp_ready[g]) busy = 1'b0;
        else age++;
      end else if (req_valid[g]) begin
        idx = int'(req_addr[g] / 4) % 256;
        mis = 1'b0;
`ifdef DATA_MEM_ALIGN_CHECK_EN
        mis = (req_addr[g] % 4) != 0;
`endif
        ee = mis;
        ek = 1'b1;
        if (mis || req_wrenable[g]) begin
          ed = 32'h0;
        end else begin
          ed = mm[idx];
          ek = kn[idx];
        end
        if (req_wrenable[g] && !mis) begin
          mm[idx] = req_wdata[g];
          kn[idx] = 1'b1;
        end
        busy = 1'b1;
        age  = 1;
      end
    end

    always @(negedge clk) begin
      if (chk_en) begin
        exp_v = busy && (age >= LAT);
        check_bit($sformatf("m%0d_req_ready", g), req_ready[g], !busy);
        check_bit($sformatf("m%0d_resp_valid", g), resp_valid[g], exp_v);
        if (exp_v) begin
          if (ek) check_eq($sformatf("m%0d_resp_rdata", g), resp_rdata[g], ed);
          check_bit($sformatf("m%0d_resp_err", g), resp_err[g], ee);
        end
      end
    end
  end

  // Issue one request, wait for its response, hold resp_ready low for stall cycles.
  task automatic xact(input int i, input logic [31:0] a, input logic [31:0] d, input logic w,
                      input int stall, output logic [31:0] rd, output logic e, output int lat);
    int t;
    rd  = '0;
    e   = 1'b0;
    lat = 0;
    @(negedge clk);
    req_valid[i]    = 1'b1;
    req_addr[i]     = a;
    req_wdata[i]    = d;
    req_wrenable[i] = w;
    resp_ready[i]   = 1'b0;
    t = 0;
    while (!req_ready[i] && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      check_bit("accept_timeout", 1'b0, 1'b1);
      req_valid[i] = 1'b0;
      return;
    end
    @(negedge clk);
    req_valid[i]    = 1'b0;
    req_addr[i]     = $urandom;
    req_wdata[i]    = $urandom;
    req_wrenable[i] = 1'($urandom_range(0, 1));
    lat = 1;
    while (!resp_valid[i] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!resp_valid[i]) begin
      check_bit("resp_timeout", 1'b0, 1'b1);
      return;
    end
    rd = resp_rdata[i];
    e  = resp_err[i];
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check_bit("stall_resp_valid", resp_valid[i], 1'b1);
      check_bit("stall_req_ready", req_ready[i], 1'b0);
    end
    resp_ready[i] = 1'b1;
    @(negedge clk);
    resp_ready[i] = 1'b0;
  endtask

  // LATENCY=1 instance with req_valid and resp_ready held high throughout.
  task automatic back_to_back();
    logic [31:0] ba [7];
    logic [31:0] bd [7];
    logic        bw [7];
    int n, last, cyc;
    ba = '{32'h40, 32'h40, 32'h44, 32'h44, 32'h40, 32'h40, 32'h40};
    bd = '{32'h11111111, 32'h0, 32'h22222222, 32'h0, 32'h0, 32'h33333333, 32'h0};
    bw = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    n = 0; last = -1; cyc = 0;
    @(negedge clk);
    resp_ready[1]   = 1'b1;
    req_valid[1]    = 1'b1;
    req_addr[1]     = ba[0];
    req_wdata[1]    = bd[0];
    req_wrenable[1] = bw[0];
    while (n < 7 && cyc < 60) begin
      if (req_ready[1]) begin
        if (last >= 0) check_eq("b2b_spacing", 32'(cyc - last), 32'd2);
        last = cyc;
        n++;
        @(negedge clk);
        cyc++;
        if (n < 7) begin
          req_addr[1]     = ba[n];
          req_wdata[1]    = bd[n];
          req_wrenable[1] = bw[n];
        end else begin
          req_valid[1] = 1'b0;
        end
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    req_valid[1] = 1'b0;
    @(negedge clk);
    resp_ready[1] = 1'b0;
    check_eq("b2b_accept_count", 32'(n), 32'd7);
  endtask

  initial begin
    logic [31:0] rd, a;
    logic        e;
    int          lat;

    for (int i = 0; i < 2; i++) begin
      reset[i]        = 1'b1;
      req_valid[i]    = 1'b0;
      req_addr[i]     = '0;
      req_wdata[i]    = '0;
      req_wrenable[i] = 1'b0;
      resp_ready[i]   = 1'b0;
    end
    repeat (3) @(negedge clk);
    reset[0] = 1'b0;
    reset[1] = 1'b0;
    chk_en   = 1'b1;

    check_bit("rst_req_ready", req_ready[0], 1'b1);
    check_bit("rst_resp_valid", resp_valid[0], 1'b0);
    check_eq("rst_resp_rdata", resp_rdata[0], 32'h0);
    check_bit("rst_resp_err", resp_err[0], 1'b0);
    check_bit("rst_req_ready_l1", req_ready[1], 1'b1);

    xact(0, 32'h10, 32'hDEADBEEF, 1'b1, 0, rd, e, lat);
    check_eq("store_latency", 32'(lat), 32'd2);
    check_eq("store_rdata", rd, 32'h0);
    xact(0, 32'h10, 32'h0, 1'b0, 0, rd, e, lat);
    check_eq("load_latency", 32'(lat), 32'd2);
    check_eq("load_rdata", rd, 32'hDEADBEEF);

    xact(0, 32'h10, 32'h0, 1'b0, 5, rd, e, lat);
    check_eq("stall_load_rdata", rd, 32'hDEADBEEF);
    check_bit("idle_after_handshake", req_ready[0], 1'b1);

    xact(0, 32'h404, 32'h12345678, 1'b1, 0, rd, e, lat);
    xact(0, 32'h004, 32'h0, 1'b0, 0, rd, e, lat);
    check_eq("alias_rdata", rd, 32'h12345678);

    @(negedge clk);
    req_valid[0] = 1'b1; req_addr[0] = 32'h20; req_wdata[0] = 32'hA5A5A5A5; req_wrenable[0] = 1'b1;
    @(negedge clk);
    req_valid[0] = 1'b0;
    reset[0] = 1'b1;
    @(negedge clk);
    reset[0] = 1'b0;
    check_bit("wait_reset_req_ready", req_ready[0], 1'b1);
    check_bit("wait_reset_resp_valid", resp_valid[0], 1'b0);
    repeat (4) begin
      @(negedge clk);
      check_bit("wait_reset_no_resp", resp_valid[0], 1'b0);
    end

    @(negedge clk);
    reset[0] = 1'b1;
    req_valid[0] = 1'b1; req_addr[0] = 32'h20; req_wdata[0] = 32'hFFFF0000; req_wrenable[0] = 1'b1;
    @(negedge clk);
    reset[0] = 1'b0;
    req_valid[0] = 1'b0;
    xact(0, 32'h20, 32'h0, 1'b0, 0, rd, e, lat);
    check_eq("store_survives_reset", rd, 32'hA5A5A5A5);

    xact(0, 32'h22, 32'h1, 1'b1, 0, rd, e, lat);
`ifdef DATA_MEM_ALIGN_CHECK_EN
    check_bit("misaligned_err", e, 1'b1);
    check_eq("misaligned_rdata", rd, 32'h0);
    xact(0, 32'h20, 32'h0, 1'b0, 0, rd, e, lat);
    check_bit("aligned_err", e, 1'b0);
    check_eq("misaligned_no_store", rd, 32'hA5A5A5A5);
`else
    check_bit("unaligned_store_err", e, 1'b0);
    check_eq("unaligned_store_rdata", rd, 32'h0);
    xact(0, 32'h20, 32'h0, 1'b0, 0, rd, e, lat);
    check_bit("containing_word_err", e, 1'b0);
    check_eq("containing_word_rdata", rd, 32'h1);
`endif

    xact(1, 32'h30, 32'h0BADF00D, 1'b1, 0, rd, e, lat);
    check_eq("l1_store_latency", 32'(lat), 32'd1);
    xact(1, 32'h30, 32'h0, 1'b0, 2, rd, e, lat);
    check_eq("l1_load_latency", 32'(lat), 32'd1);
    check_eq("l1_load_rdata", rd, 32'h0BADF00D);
    back_to_back();

    for (int i = 0; i < 2; i++) begin
      repeat (120) begin
        a = $urandom;
        a[9:2] = 8'($urandom_range(0, 15));
`ifdef DATA_MEM_ALIGN_CHECK_EN
        a[1:0] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
`endif
        xact(i, a, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3), rd, e, lat);
        check_eq($sformatf("rand%0d_latency", i), 32'(lat), 32'(lat_of(i)));
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
